// File: rtl/debug_slave_pkg.sv
// Shared types, default geometry and helpers for the debug slave command queue.
package debug_slave_pkg;

  localparam int CMD_IR_W    = 2;
  localparam int CMD_DR_W    = 38;
  localparam int CMD_DEPTH   = 4;
  localparam int CMD_ACT_BIT = 35;

  localparam int NUM_CH = 2 ** CMD_IR_W;
  localparam int PTR_W  = $clog2(CMD_DEPTH);

  typedef struct packed {
    logic [CMD_IR_W-1:0] ir;
    logic [CMD_DR_W-1:0] data;
  } cmd_t;

  // Zero-extension leaves the XOR unchanged, so narrower words can be passed in.
  function automatic logic odd_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/debug_slave_cmd_fifo.sv
// First-word fall-through command FIFO; a push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module debug_slave_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head is masked while empty so the outputs read zero out of reset.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/debug_slave_cmd_queue.sv
// System-clock side of the debug slave: strobe synchronisers, IR capture,
// command FIFO and per-channel action decode. Define DEBUG_SLAVE_PARITY_EN
// to reject DR words whose odd parity check fails.
module debug_slave_cmd_queue
  import debug_slave_pkg::*;
#(
  parameter int IR_W    = CMD_IR_W,
  parameter int DR_W    = CMD_DR_W,
  parameter int DEPTH   = CMD_DEPTH,
  parameter int ACT_BIT = CMD_ACT_BIT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vs_uir,
  input  logic                   vs_udr,
  input  logic [IR_W-1:0]        ir_in,
  input  logic [DR_W-1:0]        sr,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [IR_W-1:0]        cmd_ir,
  output logic [DR_W-1:0]        cmd_data,
  output logic [DR_W-1:0]        jdo,
  output logic [(2**IR_W)-1:0]   take_action,
  output logic [(2**IR_W)-1:0]   take_no_action,
  output logic                   cmd_ack_tgl,
  output logic                   ovf,
  input  logic                   ovf_clr,
  output logic                   par_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Bit 0 tracks vs_uir, bit 1 tracks vs_udr.
  logic [1:0]       sync1, sync2, sync3;
  logic [1:0]       fill;
  logic [1:0]       low_seen;
  logic [1:0]       sync_edge;
  logic             uir_edge;
  logic             udr_edge;
  logic             push_req;
  logic             pop;
  logic [IR_W-1:0]  ir_reg;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [IR_W+DR_W-1:0] fifo_head;

  // An edge is only honoured after a genuine low has been synchronised, so a
  // strobe still high when reset releases cannot look like a fresh rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      sync3    <= '0;
      fill     <= '0;
      low_seen <= '0;
    end else begin
      sync1    <= {vs_udr, vs_uir};
      sync2    <= sync1;
      sync3    <= sync2;
      fill     <= {fill[0], 1'b1};
      low_seen <= low_seen | ({2{fill[1]}} & ~sync2);
    end
  end

  assign sync_edge = sync2 & ~sync3 & low_seen;
  assign uir_edge  = sync_edge[0];
  assign udr_edge  = sync_edge[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_reg <= '0;
    end else if (uir_edge) begin
      ir_reg <= ir_in;
    end
  end

`ifdef DEBUG_SLAVE_PARITY_EN
  logic par_ok;

  assign par_ok   = odd_parity(64'(sr));
  assign push_req = udr_edge & par_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err <= 1'b0;
    end else begin
      par_err <= udr_edge & ~par_ok;
    end
  end
`else
  assign push_req = udr_edge;
  assign par_err  = 1'b0;
`endif

  debug_slave_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (IR_W + DR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   ({ir_reg, sr}),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cmd_valid = (fifo_count != '0);
  assign pop       = ~fifo_empty & cmd_ready;
  assign cmd_ir    = fifo_head[IR_W+DR_W-1:DR_W];
  assign cmd_data  = fifo_head[DR_W-1:0];

  // Pop side-effects are registered; a push into a full FIFO that is not
  // relieved by a pop in the same cycle is dropped and flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      cmd_ack_tgl    <= 1'b0;
      ovf            <= 1'b0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      if (pop) begin
        jdo         <= cmd_data;
        cmd_ack_tgl <= ~cmd_ack_tgl;
        if (cmd_data[ACT_BIT]) begin
          take_action[cmd_ir] <= 1'b1;
        end else begin
          take_no_action[cmd_ir] <= 1'b1;
        end
      end
      if (push_req & fifo_full & ~pop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule
